char_buffer_arbiter: RTL and testbench
======================================

CHAR_BUFFER_ARBITER -- requirements
Module: char_buffer_arbiter

Interface
REQ-001 SHALL have parameter CLEAR_CHAR, default 8'h20, the character written during a clear sequence.
REQ-002 SHALL have parameter CLEAR_ON_RESET, default 1, where 1 starts a clear sequence on reset release.
REQ-003 SHALL have port i_clk, input, 1, the single system clock.
REQ-004 SHALL have port i_rst, input, 1, an asynchronous active-high reset.
REQ-005 SHALL have port i_req, input, 3, write requests; bit k belongs to requester k.
REQ-006 SHALL have port i_addr0/i_addr1/i_addr2, input, 6 each, per-requester character address (row = [5:4], column = [3:0]).
REQ-007 SHALL have port i_data0/i_data1/i_data2, input, 8 each, per-requester character code.
REQ-008 SHALL have port o_ack, output, 3, one-cycle write-done pulse per requester.
REQ-009 SHALL have port i_clear, input, 1, a single-cycle pulse that requests a clear of the whole screen.
REQ-010 SHALL have port o_busy, output, 1, high while a clear sequence runs.
REQ-011 SHALL have port i_charAddress, input, 6, the display read address from the text renderer.
REQ-012 SHALL have port o_character, output, 8, the character stored at i_charAddress.

Function
REQ-013 SHALL hold a 64 x 8-bit character store with one write port (owned by the arbiter) and one read port.
REQ-014 Read path SHALL be registered: o_character equals store[i_charAddress] sampled at the previous clock edge, i.e. 1-cycle latency.
REQ-015 Same-cycle read and write to the same address SHALL return the old data (read-before-write).
REQ-016 FSM SHALL have two states: IDLE and CLEAR.
REQ-017 In IDLE, at each edge the arbiter SHALL select at most one eligible requester and write its addr/data to the store at that edge.
REQ-018 Requester k SHALL be eligible when i_req[k]=1 and o_ack[k]=0, so a request held through its ack cycle is not written twice.
REQ-019 Arbitration SHALL be round-robin: search order starts at (last granted + 1) mod 3; the pointer updates only on a grant.
REQ-020 o_ack[k] SHALL be high for exactly the one cycle after the edge that wrote requester k; at most one o_ack bit SHALL be high in any cycle.
REQ-021 A requester SHALL hold its req, addr and data stable until it sees its ack; the arbiter SHALL sample addr/data only at the grant edge.
REQ-022 i_clear=1 in IDLE SHALL move the FSM to CLEAR at that edge; clear SHALL take priority over simultaneous requests, which are not granted that edge.
REQ-023 CLEAR SHALL write CLEAR_CHAR to addresses 0..63 in ascending order, one per cycle, taking 64 cycles, then return to IDLE.
REQ-024 o_busy SHALL be high in every cycle in which the FSM is in CLEAR.
REQ-025 During CLEAR, no grants or acks SHALL occur; pending requests remain pending; i_clear SHALL be ignored (no restart).
REQ-026 The first grant after CLEAR SHALL occur at the edge following the write of address 63.
REQ-027 Address 63 to 0 SHALL be the only wrap; the 6-bit clear counter SHALL stop at 63 and SHALL NOT wrap.

Reset
REQ-028 While i_rst=1, the block SHALL set: o_ack=0; o_busy=CLEAR_ON_RESET; round-robin pointer such that requester 0 has highest priority; clear counter=0; FSM=CLEAR if CLEAR_ON_RESET, else IDLE; o_character=8'h00.
REQ-029 Store contents SHALL NOT be reset; with CLEAR_ON_RESET=0 they are undefined until written.
REQ-030 Reset asserted mid-clear or mid-handshake SHALL abort the operation immediately; no ack SHALL be issued for the interrupted grant.

Verification
REQ-031 Reset release with CLEAR_ON_RESET=1 -> o_busy high for 64 cycles; afterwards every address reads 8'h20 with 1-cycle latency.
REQ-032 i_req=3'b111 held, each requester drops req on its ack -> writes in order 0,1,2; acks at cycles 1, 2 and 3 after the first edge.
REQ-033 Requester 1 holds req continuously with requester 2 also requesting -> grants alternate 1,2,1,2; no address is written twice per ack.
REQ-034 i_clear together with i_req[0] (addr 6'h05, data 8'h41) -> 64-cycle clear, then grant 0; address 5 reads 8'h41 and all other addresses read 8'h20.
REQ-035 Requester 0 writes 8'h37 to address 6'h12 while i_charAddress=6'h12 -> o_character shows the old value one cycle after the edge and 8'h37 one cycle later.
REQ-036 i_rst pulsed at clear address 30 -> o_busy stays high, the clear restarts at 0 after release, and no ack occurs.

Source files
------------

// File: rtl/char_buffer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : char_buffer_arbiter
//  Purpose  : 64 x 8 character store for a text display. One write port is
//             shared by three round-robin requesters and a screen-clear
//             sequencer. One registered read port serves the text renderer.
//  Revision : 1.0 - initial release
// ============================================================================
module char_buffer_arbiter #(
   parameter logic [7:0] CLEAR_CHAR     = 8'h20,
   parameter bit         CLEAR_ON_RESET = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [2:0] i_req,
   input  logic [5:0] i_addr0,
   input  logic [5:0] i_addr1,
   input  logic [5:0] i_addr2,
   input  logic [7:0] i_data0,
   input  logic [7:0] i_data1,
   input  logic [7:0] i_data2,
   output logic [2:0] o_ack,
   input  logic       i_clear,
   output logic       o_busy,
   input  logic [5:0] i_charAddress,
   output logic [7:0] o_character
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam state_t     c_RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
   localparam logic [5:0] c_LAST_ADDR = 6'd63;
   // Pointer reset to requester 2 so the first search begins at requester 0.
   localparam logic [1:0] c_RST_LAST  = 2'd2;

   // Round-robin successor over requesters 0..2.
   function automatic logic [1:0] rr_next(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   logic [7:0] r_mem [0:63];
   logic [7:0] r_char;

   state_t     r_state,   w_state_nxt;
   logic [5:0] r_clr_cnt, w_clr_cnt_nxt;
   logic [1:0] r_last,    w_last_nxt;
   logic [2:0] r_ack,     w_ack_nxt;

   logic       w_we;
   logic [5:0] w_waddr;
   logic [7:0] w_wdata;
   logic [3:0] w_elig;
   logic [1:0] w_cand;
   logic [1:0] w_sel;
   logic       w_found;

   // Next-state, arbitration and write-port steering.
   always_comb begin
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      w_last_nxt    = r_last;
      w_ack_nxt     = 3'b000;
      w_we          = 1'b0;
      w_waddr       = r_clr_cnt;
      w_wdata       = CLEAR_CHAR;
      // A requester whose ack is showing is still holding req; skip it.
      w_elig        = {1'b0, i_req & ~r_ack};
      w_cand        = rr_next(r_last);
      w_sel         = 2'd0;
      w_found       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (i_clear) begin
               // Clear wins over any simultaneous request.
               w_state_nxt   = ST_CLEAR;
               w_clr_cnt_nxt = 6'd0;
            end else begin
               for (int i = 0; i < 3; i++) begin
                  if (!w_found && w_elig[w_cand]) begin
                     w_found = 1'b1;
                     w_sel   = w_cand;
                  end
                  w_cand = rr_next(w_cand);
               end
               if (w_found) begin
                  w_we       = 1'b1;
                  w_last_nxt = w_sel;
                  w_ack_nxt  = 3'b001 << w_sel;
                  case (w_sel)
                     2'd0:    begin w_waddr = i_addr0; w_wdata = i_data0; end
                     2'd1:    begin w_waddr = i_addr1; w_wdata = i_data1; end
                     default: begin w_waddr = i_addr2; w_wdata = i_data2; end
                  endcase
               end
            end
         end
         ST_CLEAR: begin
            w_we    = 1'b1;
            w_waddr = r_clr_cnt;
            w_wdata = CLEAR_CHAR;
            // Counter parks at the last address; re-armed on the next clear.
            if (r_clr_cnt == c_LAST_ADDR) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_clr_cnt_nxt = r_clr_cnt + 6'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Control state registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= c_RST_STATE;
         r_clr_cnt <= 6'd0;
         r_last    <= c_RST_LAST;
         r_ack     <= 3'b000;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
         r_last    <= w_last_nxt;
         r_ack     <= w_ack_nxt;
      end
   end

   // Character store write port; contents survive reset, writes do not occur under it.
   always_ff @(posedge i_clk) begin
      if (w_we && !i_rst) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   // Registered read port; old data is returned on a same-edge write.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_char <= 8'h00;
      end else begin
         r_char <= r_mem[i_charAddress];
      end
   end

   assign o_ack       = r_ack;
   assign o_busy      = (r_state == ST_CLEAR);
   assign o_character = r_char;

endmodule
`default_nettype wire

// File: tb/tb_char_buffer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_char_buffer_arbiter
//  Purpose  : Directed self-checking bench for char_buffer_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_char_buffer_arbiter;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic [2:0] i_req;
   logic [5:0] i_addr0, i_addr1, i_addr2;
   logic [7:0] i_data0, i_data1, i_data2;
   logic [2:0] o_ack;
   logic       i_clear;
   logic       o_busy;
   logic [5:0] i_charAddress;
   logic [7:0] o_character;

   int total = 0;
   int bad   = 0;
   logic [7:0] model [64];

   typedef struct {
      logic [2:0] req;
      logic [5:0] a0, a1, a2;
      logic [7:0] d0, d1, d2;
      logic [5:0] raddr;
      logic [2:0] ack;
      logic [7:0] chr;
   } vec_t;

   vec_t vecs [12];

   char_buffer_arbiter dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_req         (i_req),
      .i_addr0       (i_addr0),
      .i_addr1       (i_addr1),
      .i_addr2       (i_addr2),
      .i_data0       (i_data0),
      .i_data1       (i_data1),
      .i_data2       (i_data2),
      .o_ack         (o_ack),
      .i_clear       (i_clear),
      .o_busy        (o_busy),
      .i_charAddress (i_charAddress),
      .o_character   (o_character)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Counts cycles with busy high (checking no ack), stopping when busy drops.
   task automatic count_busy(input string name, input int pulse_at, output int n);
      n = 0;
      while (o_busy && n < 200) begin
         if (o_ack !== 3'b000) begin
            chk({name, "_ack_in_clear"}, o_ack, 3'b000);
         end
         n++;
         i_clear = (n == pulse_at);
         step();
      end
      i_clear = 1'b0;
   endtask

   task automatic read_all(input string name);
      int errs;
      errs = 0;
      for (int a = 0; a < 64; a++) begin
         i_charAddress = a[5:0];
         step();
         if (o_character !== model[a]) begin
            errs++;
            $display("FAIL %s addr %0d: got %0h expected %0h", name, a, o_character, model[a]);
         end
      end
      total++;
      if (errs != 0) bad++;
   endtask

   initial begin
      int n;

      vecs[0]  = '{3'b111, 6'h01, 6'h02, 6'h03, 8'h61, 8'h62, 8'h63, 6'h00, 3'b001, 8'h20};
      vecs[1]  = '{3'b110, 6'h01, 6'h02, 6'h03, 8'h61, 8'h62, 8'h63, 6'h02, 3'b010, 8'h20};
      vecs[2]  = '{3'b100, 6'h01, 6'h02, 6'h03, 8'h61, 8'h62, 8'h63, 6'h02, 3'b100, 8'h62};
      vecs[3]  = '{3'b000, 6'h01, 6'h02, 6'h03, 8'h61, 8'h62, 8'h63, 6'h03, 3'b000, 8'h63};
      vecs[4]  = '{3'b000, 6'h01, 6'h02, 6'h03, 8'h61, 8'h62, 8'h63, 6'h01, 3'b000, 8'h61};
      vecs[5]  = '{3'b110, 6'h00, 6'h10, 6'h11, 8'h00, 8'h71, 8'h72, 6'h00, 3'b010, 8'h20};
      vecs[6]  = '{3'b110, 6'h00, 6'h10, 6'h11, 8'h00, 8'h73, 8'h72, 6'h10, 3'b100, 8'h71};
      vecs[7]  = '{3'b110, 6'h00, 6'h10, 6'h11, 8'h00, 8'h73, 8'h72, 6'h10, 3'b010, 8'h71};
      vecs[8]  = '{3'b110, 6'h00, 6'h10, 6'h11, 8'h00, 8'h73, 8'h72, 6'h10, 3'b100, 8'h73};
      vecs[9]  = '{3'b000, 6'h00, 6'h10, 6'h11, 8'h00, 8'h73, 8'h72, 6'h11, 3'b000, 8'h72};
      vecs[10] = '{3'b001, 6'h12, 6'h10, 6'h11, 8'h37, 8'h73, 8'h72, 6'h12, 3'b001, 8'h20};
      vecs[11] = '{3'b000, 6'h12, 6'h10, 6'h11, 8'h37, 8'h73, 8'h72, 6'h12, 3'b000, 8'h37};

      i_rst = 1'b1; i_req = 3'b000; i_clear = 1'b0; i_charAddress = 6'h00;
      i_addr0 = 6'h00; i_addr1 = 6'h00; i_addr2 = 6'h00;
      i_data0 = 8'h00; i_data1 = 8'h00; i_data2 = 8'h00;

      // Reset state
      step(); step();
      chk("rst_ack", o_ack, 3'b000);
      chk("rst_busy", o_busy, 1'b1);
      chk("rst_char", o_character, 8'h00);

      // Clear on reset release: 64 busy cycles, then all addresses blank
      i_rst = 1'b0;
      count_busy("por", 0, n);
      chk("por_busy_cycles", n, 64);
      for (int a = 0; a < 64; a++) model[a] = 8'h20;
      read_all("por_read");

      // Table-driven arbitration / read-latency vectors
      for (int v = 0; v < 12; v++) begin
         i_req = vecs[v].req;
         i_addr0 = vecs[v].a0; i_addr1 = vecs[v].a1; i_addr2 = vecs[v].a2;
         i_data0 = vecs[v].d0; i_data1 = vecs[v].d1; i_data2 = vecs[v].d2;
         i_charAddress = vecs[v].raddr;
         step();
         chk($sformatf("vec%0d_ack", v), o_ack, vecs[v].ack);
         chk($sformatf("vec%0d_busy", v), o_busy, 1'b0);
         chk($sformatf("vec%0d_char", v), o_character, vecs[v].chr);
      end

      // Clear with a simultaneous request; a mid-clear pulse must not restart it
      i_req = 3'b001; i_addr0 = 6'h05; i_data0 = 8'h41; i_clear = 1'b1;
      step();
      i_clear = 1'b0;
      chk("clr_start_ack", o_ack, 3'b000);
      chk("clr_start_busy", o_busy, 1'b1);
      count_busy("clr", 10, n);
      chk("clr_busy_cycles", n, 64);
      chk("clr_end_ack", o_ack, 3'b000);
      step();
      chk("clr_grant0", o_ack, 3'b001);
      i_req = 3'b000;
      for (int a = 0; a < 64; a++) model[a] = 8'h20;
      model[5] = 8'h41;
      read_all("clr_read");

      // Reset pulsed mid-clear at address 30 with a pending request
      i_req = 3'b001; i_clear = 1'b1;
      step();
      i_clear = 1'b0;
      for (int k = 0; k < 30; k++) step();
      #2 i_rst = 1'b1;
      #1;
      chk("midrst_busy", o_busy, 1'b1);
      chk("midrst_ack", o_ack, 3'b000);
      chk("midrst_char", o_character, 8'h00);
      step();
      i_rst = 1'b0;
      count_busy("rclr", 0, n);
      chk("rclr_busy_cycles", n, 64);
      step();
      chk("rclr_grant0", o_ack, 3'b001);
      i_req = 3'b000;

      // Reset landing on a grant edge: no ack may appear
      i_req = 3'b010; i_addr1 = 6'h20; i_data1 = 8'h55;
      #2 i_rst = 1'b1;
      step();
      chk("hs_rst_ack", o_ack, 3'b000);
      i_req = 3'b000;
      i_rst = 1'b0;
      count_busy("hclr", 0, n);
      chk("hclr_busy_cycles", n, 64);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
